// File: rtl/moment_bank_ram.sv
// moment_bank_ram: CHANNELS-wide signed moment store with masked writes, pipelined reads and zero-fill sweep.
// Define MOMENT_BANK_RAM_FWD_EN to bypass same-address write data into a simultaneous read.
module moment_bank_ram #(
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = 64,
    parameter int CHANNELS      = 3,
    parameter int RD_LATENCY    = 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_clear_req,
    output logic                           o_busy,
    input  logic                           i_wr_en,
    input  logic [CHANNELS-1:0]            i_wr_mask,
    input  logic [ADDRESS_WIDTH-1:0]       i_wr_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] i_wr_data,
    input  logic                           i_rd_en,
    input  logic [ADDRESS_WIDTH-1:0]       i_rd_addr,
    output logic [CHANNELS*DATA_WIDTH-1:0] o_rd_data,
    output logic                           o_rd_valid
);
    typedef enum logic {S_CLEAR, S_IDLE} state_t;
    localparam logic [ADDRESS_WIDTH:0]   LP_DEPTH = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] LP_LAST  = ADDRESS_WIDTH'(DEPTH-1);
    state_t                          r_state, w_state_nxt;
    logic [ADDRESS_WIDTH-1:0]        r_cnt, w_cnt_nxt;
    logic                            w_clearing, w_wr_acc, w_rd_acc, w_rd_in, r_rd_valid1;
    logic [CHANNELS*DATA_WIDTH-1:0]  w_rd_data1;

    assign w_clearing = r_state == S_CLEAR;
    assign w_wr_acc   = !w_clearing && i_wr_en && ({1'b0, i_wr_addr} < LP_DEPTH);
    assign w_rd_acc   = !w_clearing && i_rd_en;
    assign w_rd_in    = {1'b0, i_rd_addr} < LP_DEPTH;
    assign o_busy     = w_clearing;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_CLEAR;
            r_cnt       <= '0;
            r_rd_valid1 <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rd_valid1 <= w_rd_acc;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_clearing) begin
            w_cnt_nxt   = (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
            w_state_nxt = (r_cnt == LP_LAST) ? S_IDLE : S_CLEAR;
        end else if (i_clear_req) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_CLEAR;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [DATA_WIDTH-1:0] r_q, w_wr_slice;
        logic                  w_we, w_fwd;
        assign w_wr_slice = i_wr_data[c*DATA_WIDTH +: DATA_WIDTH];
        assign w_we       = w_clearing || (w_wr_acc && i_wr_mask[c]);
`ifdef MOMENT_BANK_RAM_FWD_EN
        assign w_fwd = w_wr_acc && i_wr_mask[c] && (i_wr_addr == i_rd_addr);
`else
        assign w_fwd = 1'b0;
`endif
        // Storage has no reset so it maps onto block RAM; the sweep zeroes it instead.
        always_ff @(posedge i_clk) begin
            if (w_we)
                r_mem[w_clearing ? r_cnt : i_wr_addr] <= w_clearing ? '0 : w_wr_slice;
        end
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset)
                r_q <= '0;
            else if (w_rd_acc)
                r_q <= w_fwd ? w_wr_slice : (w_rd_in ? r_mem[i_rd_addr] : '0);
        end
        assign w_rd_data1[c*DATA_WIDTH +: DATA_WIDTH] = r_q;
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                           r_rd_valid2;
        logic [CHANNELS*DATA_WIDTH-1:0] r_rd_data2;
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_rd_valid2 <= 1'b0;
                r_rd_data2  <= '0;
            end else begin
                r_rd_valid2 <= r_rd_valid1;
                if (r_rd_valid1)
                    r_rd_data2 <= w_rd_data1;
            end
        end
        assign o_rd_valid = r_rd_valid2;
        assign o_rd_data  = r_rd_data2;
    end else begin : g_lat1
        assign o_rd_valid = r_rd_valid1;
        assign o_rd_data  = w_rd_data1;
    end
endmodule

// File: tb/tb_moment_bank_ram.sv
// tb_moment_bank_ram: scoreboard bench for moment_bank_ram with directed vectors.
// Honours MOMENT_BANK_RAM_FWD_EN when predicting same-address read-during-write results.
module tb_moment_bank_ram;
    localparam int LAT = 1;
    localparam logic [63:0] M5 = 64'hFFFF_FFFF_FFFF_FFFB;
`ifdef MOMENT_BANK_RAM_FWD_EN
    localparam logic [63:0] COLL_CH0 = 64'd9;
`else
    localparam logic [63:0] COLL_CH0 = 64'd1;
`endif
    logic clk = 0, rst = 0, clear_req = 0, wr_en = 0, rd_en = 0, busy, rd_valid;
    logic [2:0] wr_mask = '0;
    logic [7:0] wr_addr = '0, rd_addr = '0;
    logic [191:0] wr_data = '0, rd_data;
    int cyc = 0, errors = 0, checks = 0, n;
    typedef struct {logic [191:0] data; int due;} exp_t;
    exp_t q[$];

    moment_bank_ram #(.RD_LATENCY(LAT)) dut (
        .i_clk(clk), .i_reset(rst), .i_clear_req(clear_req), .o_busy(busy),
        .i_wr_en(wr_en), .i_wr_mask(wr_mask), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rd_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd_valid cyc=%0d got=%h", cyc, rd_data);
            end else begin
                e = q.pop_front();
                if (rd_data !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL read got=%h at cyc %0d want=%h at cyc %0d", rd_data, cyc, e.data, e.due);
                end
            end
        end
    end

    function automatic logic [191:0] pack(input logic [63:0] c2, c1, c0);
        return {c2, c1, c0};
    endfunction

    task automatic check(input string name, input logic [191:0] got, want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] m, input logic [7:0] wa, input logic [191:0] wd,
                         input logic re, input logic [7:0] ra, input logic [191:0] exp);
        wr_en = we; wr_mask = m; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
        if (re) q.push_back('{exp, cyc + LAT});
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        wr_en = 0; rd_en = 0; clear_req = 0;
        repeat (k) @(negedge clk);
    endtask

    task automatic sweep(input bit poke, output int len);
        len = 0;
        while (busy === 1'b1 && len < 1000) begin
            wr_en = poke; rd_en = poke; wr_mask = '1; wr_addr = 8'h10; rd_addr = 8'h10;
            wr_data = {3{64'hDEAD_BEEF}};
            len++;
            @(negedge clk);
        end
        wr_en = 0; rd_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [191:0] d1;
        d1 = pack(M5, 64'h0100_0000_0000_0000, 64'd1);
        #1 rst = 1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 0;
        sweep(0, n);
        check("busy_len_reset", n, 256);
        drive(0, 0, 0, 0, 1, 8'd0, 0);
        drive(0, 0, 0, 0, 1, 8'd128, 0);
        drive(0, 0, 0, 0, 1, 8'd255, 0);
        idle(2);
        drive(1, 3'b111, 8'h10, d1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 8'h10, d1);
        idle(2);
        drive(1, 3'b010, 8'h10, pack(64'hAAAA, 64'd7, 64'hBBBB), 0, 0, 0);
        drive(0, 0, 0, 0, 1, 8'h10, pack(M5, 64'd7, 64'd1));
        drive(1, 3'b000, 8'h10, {3{64'hFFFF_FFFF_FFFF_FFFF}}, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 8'h10, pack(M5, 64'd7, 64'd1));
        drive(1, 3'b001, 8'h10, pack(64'h33, 64'h44, 64'd9), 1, 8'h10, pack(M5, 64'd7, COLL_CH0));
        drive(0, 0, 0, 0, 1, 8'h10, pack(M5, 64'd7, 64'd9));
        idle(3);
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        sweep(1, n);
        check("busy_len_clear", n, 256);
        drive(0, 0, 0, 0, 1, 8'h10, 0);
        drive(1, 3'b111, 8'h20, d1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 8'h20, d1);
        idle(3);
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        repeat (100) @(negedge clk);
        rst = 1;
        repeat (3) begin
            #1;
            check("midrst_busy", busy, 1);
            check("midrst_rd_valid", rd_valid, 0);
            check("midrst_rd_data", rd_data, 0);
            @(negedge clk);
        end
        rst = 0;
        sweep(0, n);
        check("busy_len_midrst", n, 256);
        drive(0, 0, 0, 0, 1, 8'h20, 0);
        idle(4);
        check("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/moment_bank_ram.md
Name: moment_bank_ram

Overview:
- Multi-channel moment store for the LBM lattice. Holds CHANNELS signed moments (e.g. rho, ux, uy) per lattice node, with one write port and one read port in the same cycle.
- Per-channel write masking, pipelined reads with a valid flag, and a hardware zero-fill sweep after reset or on request.
- Sits between the collision/streaming datapath and the macroscopic-moment consumers.

Parameters:
DEPTH, 256, number of lattice nodes (addresses)
ADDRESS_WIDTH, $clog2(DEPTH), address bits
DATA_WIDTH, 64, bits per moment (signed two's complement)
CHANNELS, 3, moments stored per node
RD_LATENCY, 1, read latency in cycles; legal values are 1 or 2

Ports:
Clk  input  1  system clock; all logic on the rising edge
Reset  input  1  asynchronous, active-high reset
clear_req  input  1  pulse; starts a zero-fill sweep when IDLE
busy  output  1  high while a sweep is running
wr_en  input  1  write strobe
wr_mask  input  CHANNELS  per-channel write enable; bit c selects channel c
wr_addr  input  ADDRESS_WIDTH  write address
wr_data  input  CHANNELS*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
rd_en  input  1  read strobe
rd_addr  input  ADDRESS_WIDTH  read address
rd_data  output  CHANNELS*DATA_WIDTH  read data, same packing as wr_data
rd_valid  output  1  qualifies rd_data for one cycle

Behaviour:
- FSM states: CLEAR, IDLE.
- While Reset is high:
  - state = CLEAR, sweep counter = 0.
  - busy = 1, rd_valid = 0, rd_data = 0, read pipeline valids = 0.
  - Memory array is not reset directly.
- CLEAR state:
  - Each rising edge writes 0 to all channels at the sweep counter, then increments the counter.
  - On the edge that writes DEPTH-1, state goes to IDLE and busy goes to 0.
  - busy is therefore high for exactly DEPTH edges after Reset is released.
- In CLEAR, wr_en, rd_en and clear_req are ignored; no rd_valid is produced.
- IDLE state:
  - clear_req = 1 moves the FSM to CLEAR on the next edge, with the counter set to 0. busy is high from that edge.
  - wr_en and rd_en sampled on the same edge as clear_req are still serviced.
- Reset asserted mid-sweep: the sweep restarts from address 0 after release.
- Write (IDLE, wr_en = 1):
  - On the edge, channel c at wr_addr takes its wr_data slice if wr_mask[c] = 1; otherwise it is unchanged.
  - wr_mask = 0 is a no-op.
- Read (IDLE, rd_en = 1):
  - RD_LATENCY = 1: rd_data and rd_valid are registered after the edge that samples rd_en.
  - RD_LATENCY = 2: an extra output register stage is added.
  - rd_valid is high exactly one cycle per accepted read. Back-to-back reads give back-to-back valids.
- rd_data holds its last value when rd_valid = 0. Reads already in flight when a sweep starts still complete.
- Read and write to the same address on the same edge: behaviour is defined by FWD_EN (see Optional Feature).
- Address range: addresses must be below DEPTH. If DEPTH is not a power of two, out-of-range writes are dropped and out-of-range reads return 0 with rd_valid = 1.
- Storage: one inferred RAM per channel, so DE2 M4K blocks are used.

Optional Feature:
- Macro: MOMENT_BANK_RAM_FWD_EN
- Defined: read-during-write on the same address returns the new wr_data for channels with wr_mask = 1, and the old data for the other channels. Implemented as a bypass mux at read-sample time.
- Undefined: read-first; the read returns the old contents on all channels.

Test Plan (DEPTH=256, DATA_WIDTH=64, CHANNELS=3):
1. Pulse Reset, then release → busy = 1 for exactly 256 edges, then 0. Reads of addresses 0, 128, 255 return 0 on all channels, rd_valid = 1 after RD_LATENCY cycles.
2. Write addr 0x10, mask 3'b111, data {ch2 = -5, ch1 = 64'h0100_0000_0000_0000, ch0 = 1} → read 0x10 returns the same three values, rd_valid pulses once at cycle +1 (RD_LATENCY = 1) and at cycle +2 (RD_LATENCY = 2).
3. Write addr 0x10, mask 3'b010, ch1 = 7 → read returns ch2 = -5, ch1 = 7, ch0 = 1.
4. Same-edge write (mask 3'b001, ch0 = 9) and read at 0x10 → FWD_EN defined: ch0 = 9; undefined: ch0 = 1; ch1 and ch2 unchanged in both builds.
5. Pulse clear_req in IDLE → busy high for 256 cycles; wr_en and rd_en in that window have no effect and produce no rd_valid. Afterwards addr 0x10 reads 0.
6. Assert Reset at sweep address 100 and hold 3 cycles → after release busy stays high for 256 edges. rd_valid = 0 and rd_data = 0 during Reset.
